// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_ctrl_pkg
// Brief    : Shared types for the MIPS run controller and bench-side peers.
// Revision : 1.0 - initial release
// ============================================================================
package mips_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_CPU_RST = 3'd2,
        ST_RUN     = 3'd3,
        ST_DRAIN   = 3'd4,
        ST_DONE    = 3'd5
    } run_state_t;

    localparam logic [31:0] C_HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        STAT_IDLE    = 2'd0,
        STAT_BUSY    = 2'd1,
        STAT_PASS    = 2'd2,
        STAT_TIMEOUT = 2'd3
    } run_status_t;

    function automatic run_status_t run_status(input logic busy, input logic done,
                                               input logic timeout);
        run_status_t s;
        s = STAT_IDLE;
        if (busy)
            s = STAT_BUSY;
        else if (done)
            s = timeout ? STAT_TIMEOUT : STAT_PASS;
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cycle_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : cycle_watchdog
// Brief    : Saturating cycle counter with clear, enable and limit compare.
// Revision : 1.0 - initial release
// ============================================================================
module cycle_watchdog #(
    parameter int WIDTH = 32,
    parameter int LIMIT = 2500
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_enable,
    output logic [WIDTH-1:0] o_count,
    output logic             o_limit_hit
);

    localparam logic [WIDTH-1:0] C_LIMIT = WIDTH'(LIMIT);
    localparam logic [WIDTH-1:0] C_MAX   = '1;

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_next;

    assign w_next = (r_count == C_MAX) ? r_count : r_count + 1'b1;
    // Flags the cycle whose increment makes the count reach the limit.
    assign o_limit_hit = i_enable && (w_next >= C_LIMIT);
    assign o_count     = r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clear)
            r_count <= '0;
        else if (i_enable)
            r_count <= w_next;
    end

endmodule
`default_nettype wire

// File: rtl/mips_run_controller.sv
`default_nettype none
// ============================================================================
// Module   : mips_run_controller
// Brief    : Loads a program into IMEM, resets and runs the MIPS core until
//            HALT fetch (plus drain) or watchdog timeout.
// Revision : 1.0 - initial release
// ============================================================================
module mips_run_controller
    import mips_ctrl_pkg::*;
#(
    parameter int          IMEM_BYTES   = 2048,
    parameter int          ADDR_W       = 11,
    parameter logic [31:0] HALT_WORD    = C_HALT_WORD_DEFAULT,
    parameter int          DRAIN_CYCLES = 4,
    parameter int          RST_CYCLES   = 2,
    parameter int          MAX_CYCLES   = 2500
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start_load,
    input  logic              i_run_start,
    input  logic              i_abort,
    input  logic              i_load_valid,
    output logic              o_load_ready,
    input  logic [7:0]        i_load_byte,
    input  logic              i_load_last,
    output logic              o_imem_we,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic [7:0]        o_imem_wdata,
    output logic              o_cpu_rst_n,
    output logic              o_cpu_enable,
    input  logic [31:0]       i_if_instruction,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_timeout,
    output logic [31:0]       o_cycle_count
);

    localparam logic [ADDR_W-1:0] C_LAST_ADDR  = ADDR_W'(IMEM_BYTES - 1);
    localparam logic [7:0]        C_RST_LAST   = 8'(RST_CYCLES - 1);
    localparam logic [7:0]        C_DRAIN_LAST = 8'(DRAIN_CYCLES - 1);

    run_state_t        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_phase;
    logic              r_load_ready;
    logic              r_cpu_rst_n;
    logic              r_cpu_enable;
    logic              r_busy;
    logic              r_done;
    logic              r_timeout;

    logic w_cmd_window;
    logic w_load_hs;
    logic w_load_final;
    logic w_wd_clear;
    logic w_wd_enable;
    logic w_limit_hit;
    logic w_halt;

    assign w_cmd_window = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_load_hs    = (r_state == ST_LOAD) && r_load_ready && i_load_valid
                          && !i_abort && !rst;
    assign w_load_final = i_load_last || (r_addr == C_LAST_ADDR);
    assign w_halt       = (i_if_instruction == HALT_WORD);
    assign w_wd_clear   = !i_abort && ((r_state == ST_CPU_RST) ||
                          (w_cmd_window && i_run_start && !i_start_load));
    assign w_wd_enable  = !i_abort && ((r_state == ST_RUN) || (r_state == ST_DRAIN));

    cycle_watchdog #(
        .WIDTH (32),
        .LIMIT (MAX_CYCLES)
    ) u_watchdog (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (w_wd_clear),
        .i_enable    (w_wd_enable),
        .o_count     (o_cycle_count),
        .o_limit_hit (w_limit_hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_phase      <= '0;
            r_load_ready <= 1'b0;
            r_cpu_rst_n  <= 1'b0;
            r_cpu_enable <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_timeout    <= 1'b0;
        end else if (i_abort) begin
            r_state      <= ST_IDLE;
            r_load_ready <= 1'b0;
            r_cpu_rst_n  <= 1'b0;
            r_cpu_enable <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (i_start_load) begin
                        r_state      <= ST_LOAD;
                        r_addr       <= '0;
                        r_load_ready <= 1'b1;
                        r_cpu_rst_n  <= 1'b0;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                        r_timeout    <= 1'b0;
                    end else if (i_run_start) begin
                        r_state     <= ST_CPU_RST;
                        r_phase     <= '0;
                        r_cpu_rst_n <= 1'b0;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_timeout   <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (w_load_hs) begin
                        // Address saturates at the top of memory; no wrap to 0.
                        if (r_addr != C_LAST_ADDR)
                            r_addr <= r_addr + 1'b1;
                        if (w_load_final) begin
                            r_state      <= ST_CPU_RST;
                            r_phase      <= '0;
                            r_load_ready <= 1'b0;
                        end
                    end
                end
                ST_CPU_RST: begin
                    if (r_phase == C_RST_LAST) begin
                        r_state      <= ST_RUN;
                        r_cpu_rst_n  <= 1'b1;
                        r_cpu_enable <= 1'b1;
                    end else begin
                        r_phase <= r_phase + 1'b1;
                    end
                end
                ST_RUN, ST_DRAIN: begin
                    if (w_limit_hit) begin
                        r_state      <= ST_DONE;
                        r_cpu_enable <= 1'b0;
                        r_busy       <= 1'b0;
                        r_done       <= 1'b1;
                        r_timeout    <= 1'b1;
                    end else if (r_state == ST_RUN) begin
                        if (w_halt) begin
                            r_state <= ST_DRAIN;
                            r_phase <= '0;
                        end
                    end else if (r_phase == C_DRAIN_LAST) begin
                        r_state      <= ST_DONE;
                        r_cpu_enable <= 1'b0;
                        r_busy       <= 1'b0;
                        r_done       <= 1'b1;
                    end else begin
                        r_phase <= r_phase + 1'b1;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_load_ready <= 1'b0;
                    r_cpu_rst_n  <= 1'b0;
                    r_cpu_enable <= 1'b0;
                    r_busy       <= 1'b0;
                    r_done       <= 1'b0;
                end
            endcase
        end
    end

    assign o_load_ready = r_load_ready;
    assign o_imem_we    = w_load_hs;
    assign o_imem_addr  = r_addr;
    assign o_imem_wdata = i_load_byte;
    assign o_cpu_rst_n  = r_cpu_rst_n;
    assign o_cpu_enable = r_cpu_enable;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_timeout    = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_mips_run_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_run_controller
// Brief    : Scoreboard bench for mips_run_controller (load, run, timeout, abort).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_run_controller;

    localparam int IMEM_BYTES = 2048;
    localparam int ADDR_W     = 11;
    localparam int MAX_CYCLES = 20;

    typedef struct packed {
        logic        timeout;
        logic [31:0] count;
    } run_exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              start_load, run_start, abort;
    logic              load_valid, load_last;
    logic [7:0]        load_byte;
    logic              load_ready, imem_we, cpu_rst_n, cpu_enable;
    logic              busy, done, timeout;
    logic [ADDR_W-1:0] imem_addr;
    logic [7:0]        imem_wdata;
    logic [31:0]       cycle_count;
    logic [31:0]       if_instr = 32'h0;

    run_exp_t          run_q[$];
    logic [18:0]       wr_q[$];
    int                n_checks   = 0;
    int                n_fail     = 0;
    int                n_writes   = 0;
    int                halt_after = -1;
    int                en_cycles  = 0;
    logic              done_q     = 1'b0;

    always #5 clk = ~clk;

    mips_run_controller #(
        .IMEM_BYTES   (IMEM_BYTES),
        .ADDR_W       (ADDR_W),
        .HALT_WORD    (32'hFFFF_FFFF),
        .DRAIN_CYCLES (4),
        .RST_CYCLES   (2),
        .MAX_CYCLES   (MAX_CYCLES)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .i_start_load     (start_load),
        .i_run_start      (run_start),
        .i_abort          (abort),
        .i_load_valid     (load_valid),
        .o_load_ready     (load_ready),
        .i_load_byte      (load_byte),
        .i_load_last      (load_last),
        .o_imem_we        (imem_we),
        .o_imem_addr      (imem_addr),
        .o_imem_wdata     (imem_wdata),
        .o_cpu_rst_n      (cpu_rst_n),
        .o_cpu_enable     (cpu_enable),
        .i_if_instruction (if_instr),
        .o_busy           (busy),
        .o_done           (done),
        .o_timeout        (timeout),
        .o_cycle_count    (cycle_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Program model: N ordinary fetches per run, then the HALT word.
    always @(posedge clk) begin
        #1;
        if (cpu_enable) en_cycles++;
        else en_cycles = 0;
        if (halt_after >= 0 && en_cycles == halt_after + 1)
            if_instr = 32'hFFFF_FFFF;
        else
            if_instr = 32'h0800_0000 | 32'(en_cycles);
    end

    always @(negedge clk) begin
        logic [18:0] w;
        if (imem_we) begin
            n_writes++;
            if (wr_q.size() == 0) begin
                check_eq("imem_we_unexpected", 32'd1, 32'd0);
            end else begin
                w = wr_q.pop_front();
                check_eq("imem_addr", 32'(imem_addr), 32'(w[18:8]));
                check_eq("imem_wdata", 32'(imem_wdata), 32'(w[7:0]));
            end
        end
    end

    always @(negedge clk) begin
        run_exp_t e;
        if (done && !done_q) begin
            if (run_q.size() == 0) begin
                check_eq("run_unexpected", 32'd1, 32'd0);
            end else begin
                e = run_q.pop_front();
                check_eq("run_timeout", 32'(timeout), 32'(e.timeout));
                check_eq("run_cycle_count", cycle_count, e.count);
                check_eq("run_enable_off", 32'(cpu_enable), 32'd0);
                check_eq("run_rst_n_high", 32'(cpu_rst_n), 32'd1);
                check_eq("run_busy_off", 32'(busy), 32'd0);
            end
        end
        done_q = done;
    end

    task automatic pulse_cmd(input logic sl, input logic rs);
        @(posedge clk); #1;
        start_load = sl;
        run_start  = rs;
        @(posedge clk); #1;
        start_load = 1'b0;
        run_start  = 1'b0;
    endtask

    task automatic stream(input int n, input logic use_last);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            b          = 8'($urandom);
            load_valid = 1'b1;
            load_byte  = b;
            load_last  = use_last && (i == n - 1);
            if (i < IMEM_BYTES) wr_q.push_back({11'(i), b});
        end
        @(posedge clk); #1;
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq("done_within_budget", 32'(seen), 32'd1);
    endtask

    task automatic wait_enable(input int budget);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (cpu_enable) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq("enable_within_budget", 32'(seen), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_time_limit: observed expired expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        int w0;
        int lo;
        rst = 1'b1; start_load = 1'b0; run_start = 1'b0; abort = 1'b0;
        load_valid = 1'b0; load_byte = 8'h0; load_last = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_load_ready", 32'(load_ready), 32'd0);
        check_eq("rst_imem_we", 32'(imem_we), 32'd0);
        check_eq("rst_imem_addr", 32'(imem_addr), 32'd0);
        check_eq("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        check_eq("rst_cpu_enable", 32'(cpu_enable), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_timeout", 32'(timeout), 32'd0);
        check_eq("rst_cycle_count", cycle_count, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // 8-byte load, 10 fetches then HALT: 11 RUN + 4 DRAIN cycles
        halt_after = 10;
        run_q.push_back('{1'b0, 32'd15});
        w0 = n_writes;
        pulse_cmd(1'b1, 1'b0);
        stream(8, 1'b1);
        check_eq("load8_write_count", 32'(n_writes - w0), 32'd8);
        lo = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (cpu_enable) break;
            if (!cpu_rst_n) lo++;
        end
        check_eq("cpu_rst_low_cycles", 32'(lo), 32'd2);
        check_eq("run_enable_on", 32'(cpu_enable), 32'd1);
        wait_done(100);

        // Never halts: watchdog ends the run
        halt_after = -1;
        run_q.push_back('{1'b1, 32'd20});
        pulse_cmd(1'b0, 1'b1);
        wait_done(100);

        // start_load wins over run_start; 2049-byte stream with no load_last
        halt_after = 3;
        run_q.push_back('{1'b0, 32'd8});
        pulse_cmd(1'b1, 1'b1);
        @(negedge clk);
        check_eq("both_cmd_load_ready", 32'(load_ready), 32'd1);
        check_eq("both_cmd_timeout_clr", 32'(timeout), 32'd0);
        w0 = n_writes;
        stream(IMEM_BYTES + 1, 1'b0);
        @(negedge clk);
        check_eq("full_load_ready_low", 32'(load_ready), 32'd0);
        check_eq("full_load_addr_top", 32'(imem_addr), 32'(IMEM_BYTES - 1));
        check_eq("full_load_write_count", 32'(n_writes - w0), 32'(IMEM_BYTES));
        wait_done(100);

        // start_load during RUN is ignored
        halt_after = 10;
        run_q.push_back('{1'b0, 32'd15});
        pulse_cmd(1'b0, 1'b1);
        wait_enable(50);
        @(posedge clk); #1 start_load = 1'b1;
        @(posedge clk); #1 start_load = 1'b0;
        @(negedge clk);
        check_eq("busy_load_ready", 32'(load_ready), 32'd0);
        check_eq("busy_enable_kept", 32'(cpu_enable), 32'd1);
        wait_done(100);

        // abort in RUN cycle 5, then rerun
        halt_after = -1;
        pulse_cmd(1'b0, 1'b1);
        wait_enable(50);
        repeat (4) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_enable", 32'(cpu_enable), 32'd0);
        check_eq("abort_rst_n", 32'(cpu_rst_n), 32'd0);
        check_eq("abort_count_kept", cycle_count, 32'd4);
        halt_after = 2;
        run_q.push_back('{1'b0, 32'd7});
        pulse_cmd(1'b0, 1'b1);
        @(negedge clk);
        check_eq("rerun_count_cleared", cycle_count, 32'd0);
        wait_done(100);

        @(negedge clk);
        check_eq("run_queue_empty", 32'(run_q.size()), 32'd0);
        check_eq("write_queue_empty", 32'(wr_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
